button_int_ctrl: RTL

- Responder side of the processor's hardware-interrupt interface.
- Samples the 8 raw board inputs (buttons/switches) and captures rising edges as pending interrupts.
- Presents the highest-priority unmasked pending interrupt to the control unit as a request plus a 16-bit handler vector on `interrupt_reg`.
- Holds that request through an ack / end-of-interrupt handshake, so a button pulse of ~1 clock is never lost and is never serviced twice.

---
 rtl/button_int_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/button_int_ctrl.sv
// Button interrupt responder: edge-captured pending lines, fixed priority, ack/done handshake.
// Optional debounce stage on each line is enabled with BUTTON_INT_DEBOUNCE_EN.
module button_int_ctrl #(
  parameter int          NUM_LINES       = 8,
  parameter logic [15:0] VECTOR_BASE     = 16'h0100,
  parameter logic [15:0] VECTOR_STRIDE   = 16'h0010,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_LINES-1:0] hardware,
  input  logic [NUM_LINES-1:0] int_mask,
  input  logic                 int_ack,
  input  logic                 int_done,
  output logic                 int_req,
  output logic [15:0]          interrupt_reg,
  output logic [NUM_LINES-1:0] pending,
  output logic                 in_service
);

  localparam int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t state, state_n;

  logic [NUM_LINES-1:0] sync_a, sync_q;
  logic [NUM_LINES-1:0] level, level_d, rise_q;
  logic [NUM_LINES-1:0] cand, clr;
  logic [IW-1:0]        idx, idx_n, win;
  logic                 any;
  logic                 req_n, svc_n;
  logic [15:0]          vec_n;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_a  <= '0;
      sync_q  <= '0;
      level_d <= '0;
      rise_q  <= '0;
    end else begin
      sync_a  <= hardware;
      sync_q  <= sync_a;
      level_d <= level;
      rise_q  <= level & ~level_d;
    end
  end

`ifdef BUTTON_INT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0]        cnt [NUM_LINES];
  logic [NUM_LINES-1:0] deb;

  // Level only moves after DEBOUNCE_CYCLES samples disagreeing in a row.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      deb <= '0;
      for (int i = 0; i < NUM_LINES; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (sync_q[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync_q[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = deb;
`else
  assign level = sync_q;
`endif

  function automatic logic [15:0] vec_of(input logic [IW-1:0] i);
    return VECTOR_BASE + 16'(i) * VECTOR_STRIDE;
  endfunction

  always_comb begin
    cand = pending & int_mask;
    any  = |cand;
    win  = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--)
      if (cand[i])
        win = IW'(i);
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    req_n   = int_req;
    svc_n   = in_service;
    vec_n   = interrupt_reg;
    clr     = '0;
    unique case (state)
      IDLE: begin
        if (any) begin
          idx_n   = win;
          vec_n   = vec_of(win);
          req_n   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        // Ack wins over a coincident done.
        if (int_ack) begin
          req_n   = 1'b0;
          svc_n   = 1'b1;
          clr     = NUM_LINES'(1) << idx;
          state_n = SERVICE;
        end
      end
      SERVICE: begin
        if (int_done) begin
          svc_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      idx           <= '0;
      int_req       <= 1'b0;
      in_service    <= 1'b0;
      interrupt_reg <= 16'h0000;
      pending       <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      int_req       <= req_n;
      in_service    <= svc_n;
      interrupt_reg <= vec_n;
      // A fresh edge on the acked line survives the clear.
      pending       <= (pending & ~clr) | rise_q;
    end
  end

endmodule
